// File: rtl/acc_stim_issuer_if.sv
// Upstream operand handshake into the accumulator stimulus issuer.
// The producer drives in_valid/in_data; the issuer returns in_ready.
interface acc_stim_issuer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/acc_stim_issuer.sv
// Transmit side of the enable/value accumulator link. Operands are buffered
// in a small FIFO and issued one at a time: a one-cycle enable pulse, then
// value held stable until the accumulator's add. A shadow sum predicts the
// accumulator count (and its led byte) without a readback path.
module acc_stim_issuer #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int ISSUE_GAP = 3
) (
  input  logic               CLK,
  input  logic               RST_N,
  acc_stim_issuer_if.slave   up,
  input  logic               halt,
  output logic               enable,
  output logic [WIDTH-1:0]   value,
  output logic               busy,
  output logic [15:0]        issued_cnt,
  output logic [WIDTH-1:0]   shadow_sum,
  output logic [7:0]         shadow_led
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(ISSUE_GAP);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [HW-1:0] HOLD_INIT = HW'(ISSUE_GAP - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t           state;
  logic [HW-1:0]    hold_ctr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             push;
  logic             pop;
  logic             issue_slot;

  // An issue may start from IDLE or directly at the last hold cycle, which
  // keeps back-to-back operands exactly ISSUE_GAP cycles apart.
  assign issue_slot = (state == IDLE) || (state == HOLD && hold_ctr == '0);
  assign push       = up.in_valid && up.in_ready;
  assign pop        = issue_slot && (count != '0) && !halt;
  assign shadow_led = shadow_sum[23:16];

  // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    // NOTE: default first so every path assigns count_nxt and no latch is inferred.
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

  // Operand storage write port.
  always_ff @(posedge CLK) begin
    // NOTE: storage is deliberately not reset; the pointers and count define validity.
    if (push)
      mem[wr_ptr] <= up.in_data;
  end

  // FIFO pointers, occupancy and the registered in_ready (= !full).
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      up.in_ready <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      up.in_ready <= (count_nxt != FULL_CNT);
    end
  end

  // Issue FSM: pulse enable, hold value, then fold it into the shadow state.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      hold_ctr   <= '0;
      enable     <= 1'b0;
      value      <= '0;
      busy       <= 1'b0;
      issued_cnt <= '0;
      shadow_sum <= '0;
    end else begin
      // NOTE: non-blocking everywhere here; the default below is overridden
      // by a later assignment in the same edge when a new issue starts.
      enable <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            value  <= mem[rd_ptr];
            enable <= 1'b1;
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          hold_ctr <= HOLD_INIT;
          state    <= HOLD;
        end
        HOLD: begin
          if (hold_ctr != '0) begin
            hold_ctr <= hold_ctr - 1'b1;
          end else begin
            // This edge coincides with the accumulator's add of value.
            shadow_sum <= shadow_sum + value;
            issued_cnt <= issued_cnt + 1'b1;
            if (pop) begin
              value  <= mem[rd_ptr];
              enable <= 1'b1;
              state  <= ISSUE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_stim_issuer.sv
// Bench for acc_stim_issuer: directed scenarios feed a scoreboard queue of
// expected issues; a negedge monitor pops and checks every enable pulse,
// the hold window, the shadow update, and a reference accumulator's led.
module tb_acc_stim_issuer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int GAP   = 3;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic        halt  = 1'b0;
  logic        enable;
  logic        busy;
  logic [31:0] value;
  logic [31:0] shadow_sum;
  logic [15:0] issued_cnt;
  logic [7:0]  shadow_led;

  acc_stim_issuer_if #(.WIDTH(WIDTH)) up_if ();

  acc_stim_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ISSUE_GAP(GAP)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .up         (up_if.slave),
    .halt       (halt),
    .enable     (enable),
    .value      (value),
    .busy       (busy),
    .issued_cnt (issued_cnt),
    .shadow_sum (shadow_sum),
    .shadow_led (shadow_led)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] v;
    logic [31:0] sum;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] exp_sum = '0;
  logic [15:0] exp_cnt = '0;
  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          en_log[$];
  int          hold_left = 0;
  bit          pend = 1'b0;
  int          since_en = GAP;
  logic [31:0] acc = '0;
  int          acc_st = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference accumulator: state 0 sees enable, state 1, state 2 adds value.
  always @(posedge CLK) begin
    if (!RST_N) begin
      acc    <= '0;
      acc_st <= 0;
    end else begin
      case (acc_st)
        0:       if (enable) acc_st <= 1;
        1:       acc_st <= 2;
        default: begin acc <= acc + value; acc_st <= 0; end
      endcase
    end
  end

  // Monitor / scoreboard consumer, sampling on the falling edge.
  always @(negedge CLK) begin
    cyc++;
    if (!RST_N) begin
      hold_left = 0;
      pend      = 1'b0;
      since_en  = GAP;
    end else begin
      if (pend) begin
        check("shadow_sum_update", shadow_sum, cur.sum);
        check("issued_cnt_update", 32'(issued_cnt), 32'(cur.cnt));
        check("shadow_led_update", 32'(shadow_led), 32'(cur.sum[23:16]));
        pend = 1'b0;
      end
      check("busy", 32'(busy), 32'(enable || hold_left > 0));
      check("led_vs_accumulator", 32'(shadow_led), 32'(acc[23:16]));
      if (hold_left > 0) begin
        check("value_hold", value, cur.v);
        hold_left--;
        if (hold_left == 0) pend = 1'b1;
      end
      if (since_en < GAP) since_en++;
      if (enable) begin
        assert (since_en >= GAP) else $error("enable spacing violated at cycle %0d", cyc);
        check("enable_spacing_ok", 32'(since_en >= GAP), 32'(1));
        since_en = 0;
        en_log.push_back(cyc);
        check("enable_with_empty_scoreboard", 32'(sb.size() == 0), 32'(0));
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          check("value_at_enable", value, cur.v);
          hold_left = GAP - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sb_push(input logic [31:0] v);
    exp_t e;
    exp_sum = exp_sum + v;
    exp_cnt = exp_cnt + 16'd1;
    e.v   = v;
    e.sum = exp_sum;
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    RST_N          = 1'b0;
    halt           = 1'b0;
    up_if.in_valid = 1'b0;
    up_if.in_data  = '0;
    sb.delete();
    exp_sum = '0;
    exp_cnt = '0;
    tick();
    tick();
    RST_N = 1'b1;
    en_log.delete();
    check("rst_enable", 32'(enable), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_value", value, 32'h0);
    check("rst_shadow_sum", shadow_sum, 32'h0);
    check("rst_issued_cnt", 32'(issued_cnt), 32'(0));
    check("rst_in_ready", 32'(up_if.in_ready), 32'(1));
  endtask

  // Present one operand and hold it until accepted (bounded).
  task automatic push(input logic [31:0] v);
    up_if.in_valid = 1'b1;
    up_if.in_data  = v;
    for (int i = 0; i < 200 && !up_if.in_ready; i++) tick();
    check("push_accept", 32'(up_if.in_ready), 32'(1));
    if (up_if.in_ready) sb_push(v);
    tick();
    up_if.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      idle = (sb.size() == 0) && (hold_left == 0) && !pend && !enable;
      if (idle) break;
      tick();
    end
    check("drain_done", 32'(idle), 32'(1));
  endtask

  task automatic check_gaps(input string name, input int n);
    check({name, "_count"}, 32'(en_log.size()), 32'(n));
    for (int i = 1; i < en_log.size(); i++)
      check({name, "_gap"}, 32'(en_log[i] - en_log[i-1]), 32'(GAP));
  endtask

  initial begin
    up_if.in_valid = 1'b0;
    up_if.in_data  = '0;

    // Single operand: latency, one pulse, shadow update.
    do_reset();
    up_if.in_valid = 1'b1;
    up_if.in_data  = 32'h0001_0000;
    sb_push(32'h0001_0000);
    tick();
    up_if.in_valid = 1'b0;
    check("latency_p1_no_enable", 32'(enable), 32'(0));
    tick();
    check("latency_p2_enable", 32'(enable), 32'(1));
    wait_idle();
    check_gaps("single", 1);
    check("single_shadow_sum", shadow_sum, 32'h0001_0000);
    check("single_shadow_led", 32'(shadow_led), 32'h01);
    check("single_issued_cnt", 32'(issued_cnt), 32'(1));

    // Fill the FIFO while halted, try one extra push, then release.
    do_reset();
    halt = 1'b1;
    push(32'h0001_0000);
    push(32'h0002_0000);
    push(32'h0003_0000);
    push(32'h0004_0000);
    check("full_in_ready_low", 32'(up_if.in_ready), 32'(0));
    up_if.in_valid = 1'b1;
    up_if.in_data  = 32'hDEAD_BEEF;
    tick();
    tick();
    check("full_stays_full", 32'(up_if.in_ready), 32'(0));
    up_if.in_valid = 1'b0;
    en_log.delete();
    halt = 1'b0;
    wait_idle();
    check_gaps("burst", 4);
    check("burst_shadow_led", 32'(shadow_led), 32'h0A);
    check("burst_shadow_sum", shadow_sum, 32'h000A_0000);
    check("burst_issued_cnt", 32'(issued_cnt), 32'(4));

    // Shadow sum wrap-around.
    do_reset();
    push(32'hFFFF_FFFF);
    push(32'h0000_0002);
    wait_idle();
    check("wrap_shadow_sum", shadow_sum, 32'h0000_0001);
    check("wrap_issued_cnt", 32'(issued_cnt), 32'(2));

    // halt withholds issues; halt during HOLD lets the current one finish.
    do_reset();
    halt = 1'b1;
    push(32'h0000_0100);
    push(32'h0000_0200);
    en_log.delete();
    repeat (10) tick();
    check("halt_no_enable", 32'(en_log.size()), 32'(0));
    check("halt_not_busy", 32'(busy), 32'(0));
    halt = 1'b0;
    wait_idle();
    check_gaps("unhalt", 2);
    check("unhalt_shadow_sum", shadow_sum, 32'h0000_0300);
    push(32'h0000_0400);
    push(32'h0000_0800);
    en_log.delete();
    for (int i = 0; i < 20 && !enable; i++) tick();
    check("midhold_enable_seen", 32'(enable), 32'(1));
    halt = 1'b1;
    repeat (10) tick();
    check("midhold_one_issue", 32'(en_log.size()), 32'(1));
    check("midhold_issued_cnt", 32'(issued_cnt), 32'(3));
    check("midhold_shadow_sum", shadow_sum, 32'h0000_0700);
    halt = 1'b0;
    wait_idle();
    check("midhold_final_cnt", 32'(issued_cnt), 32'(4));
    check("midhold_final_sum", shadow_sum, 32'h0000_0F00);

    // Reset during HOLD abandons the operand.
    do_reset();
    push(32'h0000_0005);
    for (int i = 0; i < 20 && !enable; i++) tick();
    check("rsthold_enable_seen", 32'(enable), 32'(1));
    tick();
    do_reset();
    repeat (5) tick();
    check("rsthold_no_reissue", 32'(en_log.size()), 32'(0));
    check("rsthold_shadow_sum", shadow_sum, 32'h0);
    check("rsthold_in_ready", 32'(up_if.in_ready), 32'(1));

    // Random push/halt traffic alongside the reference accumulator.
    do_reset();
    repeat (10000) begin
      halt           = ($urandom_range(0, 5) == 0);
      up_if.in_valid = ($urandom_range(0, 2) != 0);
      up_if.in_data  = $urandom();
      if (up_if.in_valid && up_if.in_ready) sb_push(up_if.in_data);
      tick();
    end
    up_if.in_valid = 1'b0;
    halt = 1'b0;
    wait_idle();
    check("random_shadow_sum", shadow_sum, exp_sum);
    check("random_issued_cnt", 32'(issued_cnt), 32'(exp_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
